// File: rtl/console_pkg.sv
// Shared definitions for the text console controller: grid widths, control
// codes and the controller state encoding.
package console_pkg;

  localparam int X_W = 7;
  localparam int Y_W = 5;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;
  localparam logic [7:0] CC_DEL = 8'h7F;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  // Codes that produce a glyph: everything from space upward except DEL.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c != CC_DEL);
  endfunction

endpackage

// File: rtl/grid_sweep.sv
// Row/column sweep counter used for both full-screen and single-row clears.
// Emits one (x,y) per cycle while valid; done marks the final cell.
module grid_sweep
  import console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           row_only,
  input  logic [Y_W-1:0] row,
  output logic           valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  logic           active_reg;
  logic           row_mode_reg;
  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;
  logic           last;

  assign last = (x_reg == X_LAST) && (row_mode_reg || (y_reg == Y_LAST));

  // Reset arms a full-screen sweep from (0,0) so the screen is blanked at power-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg   <= 1'b1;
      row_mode_reg <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
    end else if (start) begin
      active_reg   <= 1'b1;
      row_mode_reg <= row_only;
      x_reg        <= '0;
      y_reg        <= row_only ? row : '0;
    end else if (active_reg) begin
      if (last) begin
        active_reg <= 1'b0;
        x_reg      <= '0;
      end else if (x_reg == X_LAST) begin
        x_reg <= '0;
        y_reg <= y_reg + Y_W'(1);
      end else begin
        x_reg <= x_reg + X_W'(1);
      end
    end
  end

  assign valid = active_reg;
  assign x     = x_reg;
  assign y     = y_reg;
  assign done  = active_reg & last;

endmodule

// File: rtl/text_console_ctrl.sv
// Character-stream to tile-buffer write sequencer with cursor, control codes
// and clear sweeps; all write-port outputs are registered.
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int         COLS = 80,
  parameter int         ROWS = 30,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_data,
  input  logic           in_attr,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           we,
  output logic [X_W-1:0] wx,
  output logic [Y_W-1:0] wy,
  output logic [8:0]     wd,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic           busy
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  state_t         state_reg, state_next;
  logic [X_W-1:0] cur_x_reg, cur_x_next;
  logic [Y_W-1:0] cur_y_reg, cur_y_next;
  logic           we_reg, we_next;
  logic [X_W-1:0] wx_reg, wx_next;
  logic [Y_W-1:0] wy_reg, wy_next;
  logic [8:0]     wd_reg, wd_next;

  logic           sweep_start;
  logic           sweep_row_only;
  logic           sweep_valid;
  logic           sweep_done;
  logic [X_W-1:0] sweep_x;
  logic [Y_W-1:0] sweep_y;
  logic [Y_W-1:0] next_row;
  logic           accept;

  grid_sweep #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_sweep (
    .clk     (clk),
    .rst     (rst),
    .start   (sweep_start),
    .row_only(sweep_row_only),
    .row     (next_row),
    .valid   (sweep_valid),
    .x       (sweep_x),
    .y       (sweep_y),
    .done    (sweep_done)
  );

  assign next_row = (cur_y_reg == Y_LAST) ? '0 : cur_y_reg + Y_W'(1);
  assign accept   = in_valid && (state_reg == IDLE);

  always_comb begin
    state_next     = state_reg;
    cur_x_next     = cur_x_reg;
    cur_y_next     = cur_y_reg;
    we_next        = 1'b0;
    wx_next        = wx_reg;
    wy_next        = wy_reg;
    wd_next        = wd_reg;
    sweep_start    = 1'b0;
    sweep_row_only = 1'b0;

    case (state_reg)
      CLR_ALL, CLR_ROW: begin
        if (sweep_valid) begin
          we_next = 1'b1;
          wx_next = sweep_x;
          wy_next = sweep_y;
          wd_next = {1'b0, FILL};
        end
        if (sweep_done) begin
          state_next = IDLE;
          if (state_reg == CLR_ALL) begin
            cur_x_next = '0;
            cur_y_next = '0;
          end
        end
      end

      IDLE: begin
        if (accept) begin
          if (is_printable(in_data)) begin
            we_next = 1'b1;
            wx_next = cur_x_reg;
            wy_next = cur_y_reg;
            wd_next = {in_attr, in_data};
            if (cur_x_reg < X_LAST) begin
              cur_x_next = cur_x_reg + X_W'(1);
            end else begin
              // No scrolling: wrapping onto a row means blanking that row.
              cur_x_next     = '0;
              cur_y_next     = next_row;
              sweep_start    = 1'b1;
              sweep_row_only = 1'b1;
              state_next     = CLR_ROW;
            end
          end else begin
            case (in_data)
              CC_LF: begin
                cur_x_next     = '0;
                cur_y_next     = next_row;
                sweep_start    = 1'b1;
                sweep_row_only = 1'b1;
                state_next     = CLR_ROW;
              end
              CC_CR: cur_x_next = '0;
              CC_BS: begin
                if (cur_x_reg != '0) begin
                  cur_x_next = cur_x_reg - X_W'(1);
                  we_next    = 1'b1;
                  wx_next    = cur_x_reg - X_W'(1);
                  wy_next    = cur_y_reg;
                  wd_next    = {1'b0, FILL};
                end
              end
              CC_FF: begin
                sweep_start = 1'b1;
                state_next  = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      default: state_next = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLR_ALL;
      cur_x_reg <= '0;
      cur_y_reg <= '0;
      we_reg    <= 1'b0;
      wx_reg    <= '0;
      wy_reg    <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cur_x_reg <= cur_x_next;
      cur_y_reg <= cur_y_next;
      we_reg    <= we_next;
      wx_reg    <= wx_next;
      wy_reg    <= wy_next;
      wd_reg    <= wd_next;
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = ~in_ready;
  assign we       = we_reg;
  assign wx       = wx_reg;
  assign wy       = wy_reg;
  assign wd       = wd_reg;
  assign cur_x    = cur_x_reg;
  assign cur_y    = cur_y_reg;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: write scoreboard, vector table
// for single-byte behaviour, and hand-written clear/wrap/reset sequences.
module tb_text_console_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_attr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       we;
  logic [6:0] wx;
  logic [4:0] wy;
  logic [8:0] wd;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  text_console_ctrl #(.COLS(80), .ROWS(30), .FILL(8'h20)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_attr (in_attr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .we      (we),
    .wx      (wx),
    .wy      (wy),
    .wd      (wd),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] x;
    logic [4:0] y;
    logic [8:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    logic       attr;
    logic       wr;
    logic [6:0] ex;
    logic [4:0] ey;
    logic [8:0] ed;
    logic [6:0] cx;
    logic [4:0] cy;
    logic       rowclr;
  } vec_t;

  wr_t  q[$];
  vec_t vecs[12];
  int   vectors = 0;
  int   miscompares = 0;
  int   wcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Every wait goes through here so write checking happens in one process.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (we === 1'b1) begin
      wcount++;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got (%0d,%0d,%h), required no write", wx, wy, wd);
      end else begin
        e = q.pop_front();
        if ({wx, wy, wd} !== {e.x, e.y, e.d}) begin
          miscompares++;
          $display("FAIL write: got (%0d,%0d,%h), required (%0d,%0d,%h)",
                   wx, wy, wd, e.x, e.y, e.d);
        end
      end
    end
  endtask

  task automatic push_w(input int x, input int y, input logic [8:0] d);
    wr_t e;
    e.x = 7'(x);
    e.y = 5'(y);
    e.d = d;
    q.push_back(e);
  endtask

  task automatic push_row(input int y);
    for (int x = 0; x < 80; x++) push_w(x, y, 9'h020);
  endtask

  task automatic push_all(input int n);
    for (int i = 0; i < n; i++) push_w(i % 80, i / 80, 9'h020);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    if (in_ready !== 1'b1) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Presents a byte for one accepted cycle; returns on the negedge after acceptance.
  task automatic send(input logic [7:0] d, input logic a);
    int n;
    wait_ready(n);
    in_data  = d;
    in_attr  = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic settle();
    int n;
    wait_ready(n);
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;

    vecs[0]  = '{8'h41, 1'b1, 1'b1, 7'd0, 5'd0, 9'h141, 7'd1, 5'd0, 1'b0};
    vecs[1]  = '{8'h62, 1'b0, 1'b1, 7'd1, 5'd0, 9'h062, 7'd2, 5'd0, 1'b0};
    vecs[2]  = '{8'h80, 1'b0, 1'b1, 7'd2, 5'd0, 9'h080, 7'd3, 5'd0, 1'b0};
    vecs[3]  = '{8'hFF, 1'b1, 1'b1, 7'd3, 5'd0, 9'h1FF, 7'd4, 5'd0, 1'b0};
    vecs[4]  = '{8'h7F, 1'b1, 1'b0, 7'd0, 5'd0, 9'h000, 7'd4, 5'd0, 1'b0};
    vecs[5]  = '{8'h01, 1'b0, 1'b0, 7'd0, 5'd0, 9'h000, 7'd4, 5'd0, 1'b0};
    vecs[6]  = '{8'h08, 1'b1, 1'b1, 7'd3, 5'd0, 9'h020, 7'd3, 5'd0, 1'b0};
    vecs[7]  = '{8'h0D, 1'b0, 1'b0, 7'd0, 5'd0, 9'h000, 7'd0, 5'd0, 1'b0};
    vecs[8]  = '{8'h08, 1'b0, 1'b0, 7'd0, 5'd0, 9'h000, 7'd0, 5'd0, 1'b0};
    vecs[9]  = '{8'h7E, 1'b0, 1'b1, 7'd0, 5'd0, 9'h07E, 7'd1, 5'd0, 1'b0};
    vecs[10] = '{8'h0A, 1'b1, 1'b0, 7'd0, 5'd0, 9'h000, 7'd0, 5'd1, 1'b1};
    vecs[11] = '{8'h20, 1'b1, 1'b1, 7'd0, 5'd1, 9'h120, 7'd1, 5'd1, 1'b0};

    // Reset values
    repeat (3) tick();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wx", 32'(wx), 32'd0);
    chk("rst_wy", 32'(wy), 32'd0);
    chk("rst_wd", 32'(wd), 32'd0);
    chk("rst_cur_x", 32'(cur_x), 32'd0);
    chk("rst_cur_y", 32'(cur_y), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Power-up full clear
    push_all(2400);
    rst = 1'b0;
    wait_ready(n);
    chk("clr_all_busy_cycles", 32'(n), 32'd2400);
    tick();
    chk("clr_all_writes", 32'(wcount), 32'd2400);
    chk("clr_all_drained", 32'(q.size()), 32'd0);
    chk("clr_all_cur_x", 32'(cur_x), 32'd0);
    chk("clr_all_cur_y", 32'(cur_y), 32'd0);

    // Single-byte vectors from (0,0)
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) push_w(vecs[i].ex, vecs[i].ey, vecs[i].ed);
      if (vecs[i].rowclr) push_row(vecs[i].cy);
      send(vecs[i].data, vecs[i].attr);
      settle();
      chk($sformatf("vec%0d_cur_x", i), 32'(cur_x), 32'(vecs[i].cx));
      chk($sformatf("vec%0d_cur_y", i), 32'(cur_y), 32'(vecs[i].cy));
    end

    // Line wrap from (79,5) onto a cleared row 6
    send(8'h0D, 1'b0);
    settle();
    for (int r = 2; r <= 5; r++) begin
      push_row(r);
      send(8'h0A, 1'b0);
      settle();
    end
    for (int i = 0; i < 79; i++) begin
      push_w(i, 5, {1'b0, 8'(8'h61 + i % 26)});
      send(8'(8'h61 + i % 26), 1'b0);
      settle();
    end
    chk("pre_wrap_cur_x", 32'(cur_x), 32'd79);
    push_w(79, 5, 9'h05A);
    push_row(6);
    send(8'h5A, 1'b0);
    chk("wrap_cur_x", 32'(cur_x), 32'd0);
    chk("wrap_cur_y", 32'(cur_y), 32'd6);
    chk("wrap_in_ready", 32'(in_ready), 32'd0);
    wait_ready(n);
    chk("clr_row_busy_cycles", 32'(n), 32'd80);
    tick();
    chk("wrap_drained", 32'(q.size()), 32'd0);

    // LF on the last row wraps to row 0 and clears it
    for (int r = 7; r <= 29; r++) begin
      push_row(r);
      send(8'h0A, 1'b0);
      settle();
    end
    for (int i = 0; i < 3; i++) begin
      push_w(i, 29, 9'h030 + 9'(i));
      send(8'(8'h30 + i), 1'b0);
      settle();
    end
    push_row(0);
    send(8'h0A, 1'b0);
    chk("lf_wrap_cur_x", 32'(cur_x), 32'd0);
    chk("lf_wrap_cur_y", 32'(cur_y), 32'd0);
    wait_ready(n);
    chk("lf_wrap_busy_cycles", 32'(n), 32'd80);
    tick();
    chk("lf_wrap_drained", 32'(q.size()), 32'd0);

    // CR at (10,0): cursor home, no write
    for (int i = 0; i < 10; i++) begin
      push_w(i, 0, 9'h141);
      send(8'h41, 1'b1);
      settle();
    end
    chk("pre_cr_cur_x", 32'(cur_x), 32'd10);
    send(8'h0D, 1'b0);
    settle();
    chk("cr_cur_x", 32'(cur_x), 32'd0);
    chk("cr_cur_y", 32'(cur_y), 32'd0);

    // Backspace at (5,2) and at (0,2)
    for (int r = 1; r <= 2; r++) begin
      push_row(r);
      send(8'h0A, 1'b0);
      settle();
    end
    for (int i = 0; i < 5; i++) begin
      push_w(i, 2, 9'h078);
      send(8'h78, 1'b0);
      settle();
    end
    push_w(4, 2, 9'h020);
    send(8'h08, 1'b1);
    settle();
    chk("bs_cur_x", 32'(cur_x), 32'd4);
    chk("bs_cur_y", 32'(cur_y), 32'd2);
    send(8'h0D, 1'b0);
    settle();
    send(8'h08, 1'b0);
    settle();
    chk("bs0_cur_x", 32'(cur_x), 32'd0);
    chk("bs0_cur_y", 32'(cur_y), 32'd2);

    // FF, reset after 1000 cells, restart, and a byte held while busy
    wcount = 0;
    push_all(1000);
    send(8'h0C, 1'b0);
    n = 0;
    while (wcount < 1000 && n < 5000) begin
      n++;
      tick();
    end
    chk("ff_reached_1000", 32'(wcount), 32'd1000);
    rst = 1'b1;
    tick();
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_cur_y", 32'(cur_y), 32'd0);
    chk("mid_rst_drained", 32'(q.size()), 32'd0);
    wcount = 0;
    push_all(2400);
    push_w(0, 0, 9'h051);
    rst = 1'b0;
    in_data  = 8'h51;
    in_attr  = 1'b0;
    in_valid = 1'b1;
    wait_ready(n);
    chk("restart_busy_cycles", 32'(n), 32'd2400);
    tick();
    in_valid = 1'b0;
    tick();
    chk("restart_writes", 32'(wcount), 32'd2401);
    chk("held_byte_drained", 32'(q.size()), 32'd0);
    chk("held_cur_x", 32'(cur_x), 32'd1);
    chk("held_cur_y", 32'(cur_y), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
